// File: rtl/simple_processor_pkg.sv
// Shared processor types: datapath width, shift function codes, output slot states,
// and the system-level requester count for the shared shift unit.
package simple_processor_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int SHIFT_NUM_REQ = 4;

  // Encodings 4..7 are unrecognised and fall back to a right shift by rs2.
  typedef enum logic [2:0] {
    SLL  = 3'd0,
    SLLI = 3'd1,
    SLR  = 3'd2,
    SLRI = 3'd3
  } func_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu_shift.sv
// Combinational logical shift unit: register or sign-extended immediate amount;
// any amount outside 0..DATA_WIDTH-1 (including negative immediates) yields zero.
module alu_shift
  import simple_processor_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  func_t                 func,
  input  logic [5:0]            imm,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int AMT_W = $clog2(DATA_WIDTH);

  logic signed [DATA_WIDTH:0] amt_reg;
  logic signed [DATA_WIDTH:0] amt_imm;
  logic signed [DATA_WIDTH:0] amt;
  logic                       left;

  function automatic logic [DATA_WIDTH-1:0] shift_sat(input logic [DATA_WIDTH-1:0] val,
                                                      input logic signed [DATA_WIDTH:0] a,
                                                      input logic l);
    logic [AMT_W-1:0] sh;
    if (a < 0 || a >= DATA_WIDTH) return '0;
    sh = a[AMT_W-1:0];
    return l ? (val << sh) : (val >> sh);
  endfunction

  // Register amount is unsigned; one extra bit keeps it non-negative in signed compare.
  assign amt_reg = $signed({1'b0, rs2});
  assign amt_imm = $signed({{(DATA_WIDTH-5){imm[5]}}, imm});

  always_comb begin
    left = 1'b0;
    amt  = amt_reg;
    case (func)
      SLL:  left = 1'b1;
      SLLI: begin
        left = 1'b1;
        amt  = amt_imm;
      end
      SLR:  left = 1'b0;
      SLRI: amt = amt_imm;
      default: left = 1'b0;
    endcase
  end

  assign result = shift_sat(rs1, amt, left);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with internal pointer; pointer moves past the winner on advance.
// ALU_SHIFT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority with no pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef ALU_SHIFT_ARB_FIXED_PRIO_EN

  logic found;
  logic unused_ctrl;

  assign unused_ctrl = ^{clk_i, rst_ni, advance};

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
      end
    end
  end

`else

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic            found;
  int              idx;

  // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_idx  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (advance && found) begin
      rr_ptr <= ID_W'((int'(win_idx) + 1) % NUM_REQ);
    end
  end

`endif

endmodule

// File: rtl/alu_shift_arbiter.sv
// Shares one alu_shift among NUM_REQ requesters with a one-entry valid/ready result slot.
// Arbitration is round-robin unless ALU_SHIFT_ARB_FIXED_PRIO_EN is defined.
module alu_shift_arbiter
  import simple_processor_pkg::*;
#(
  parameter int NUM_REQ = SHIFT_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_rs1_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_rs2_i,
  input  func_t [NUM_REQ-1:0]                 req_func_i,
  input  logic [NUM_REQ-1:0][5:0]             req_imm_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [DATA_WIDTH-1:0]               rsp_data_o,
  output logic [ID_W-1:0]                     rsp_id_o
);

  slot_state_t           state_q;
  slot_state_t           state_d;
  logic [NUM_REQ-1:0]    gnt;
  logic                  slot_free;
  logic                  push;
  logic [ID_W-1:0]       win_id;
  logic [DATA_WIDTH-1:0] rs1_sel;
  logic [DATA_WIDTH-1:0] rs2_sel;
  func_t                 func_sel;
  logic [5:0]            imm_sel;
  logic [DATA_WIDTH-1:0] shift_res;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [ID_W-1:0]       id_p0;

  assign slot_free   = (state_q == SLOT_EMPTY) || rsp_ready_i;
  assign push        = slot_free && (|req_valid_i);
  assign req_ready_o = gnt & {NUM_REQ{slot_free}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_valid_i),
    .advance (push),
    .gnt     (gnt)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_id = ID_W'(i);
    end
  end

  assign rs1_sel  = req_rs1_i[win_id];
  assign rs2_sel  = req_rs2_i[win_id];
  assign func_sel = req_func_i[win_id];
  assign imm_sel  = req_imm_i[win_id];

  alu_shift u_shift (
    .rs1    (rs1_sel),
    .rs2    (rs2_sel),
    .func   (func_sel),
    .imm    (imm_sel),
    .result (shift_res)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_o = (state_q == SLOT_FULL);
    case (state_q)
      SLOT_EMPTY: if (push) state_d = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready_i && !push) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p0: result slot; held stable while full and not popped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_p0 <= '0;
      id_p0   <= '0;
    end else if (push) begin
      data_p0 <= shift_res;
      id_p0   <= win_id;
    end
  end

  assign rsp_data_o = data_p0;
  assign rsp_id_o   = id_p0;

endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Directed bench for alu_shift_arbiter: reset, arbitration order, backpressure,
// shift amount boundaries, reset while full and sparse requests.
module tb_alu_shift_arbiter;
  import simple_processor_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic [3:0]                req_valid;
  logic [3:0]                req_ready;
  logic [3:0][31:0]          req_rs1;
  logic [3:0][31:0]          req_rs2;
  func_t [3:0]               req_func;
  logic [3:0][5:0]           req_imm;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_data;
  logic [1:0]                rsp_id;

  int n_assert = 0;
  int n_fail   = 0;

  alu_shift_arbiter #(.NUM_REQ(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .req_func_i  (req_func),
    .req_imm_i   (req_imm),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_reqs();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      req_rs1[i]  = '0;
      req_rs2[i]  = '0;
      req_func[i] = SLL;
      req_imm[i]  = '0;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] rs1, input logic [31:0] rs2,
                         input func_t f, input logic [5:0] imm);
    req_valid[i] = 1'b1;
    req_rs1[i]   = rs1;
    req_rs2[i]   = rs2;
    req_func[i]  = f;
    req_imm[i]   = imm;
  endtask

  task automatic shift_case(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                            input func_t f, input logic [5:0] imm, input logic [31:0] exp);
    set_req(0, rs1, rs2, f, imm);
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'h1);
    tick();
    check({tag, "_data"}, 64'(rsp_data), 64'(exp));
    check({tag, "_id"}, 64'(rsp_id), 64'h0);
  endtask

`ifdef ALU_SHIFT_ARB_FIXED_PRIO_EN
  int          ord_id[5]    = '{0, 0, 0, 0, 0};
  logic [31:0] ord_data[5]  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
  int          bp_id        = 0;
  logic [31:0] bp_data      = 32'd1;
  logic [3:0]  final_ready  = 4'b0001;
`else
  int          ord_id[5]    = '{0, 1, 2, 3, 0};
  logic [31:0] ord_data[5]  = '{32'd1, 32'd4, 32'd12, 32'd32, 32'd1};
  int          bp_id        = 1;
  logic [31:0] bp_data      = 32'd4;
  logic [3:0]  final_ready  = 4'b0100;
`endif

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    clr_reqs();

    // Reset and single request
    tick();
    tick();
    check("rst_valid", 64'(rsp_valid), 64'h0);
    check("rst_data", 64'(rsp_data), 64'h0);
    check("rst_id", 64'(rsp_id), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h0);
    rst_n = 1'b1;
    set_req(2, 32'h0000_00F0, 32'h0, SLRI, 6'd4);
    #1;
    check("single_ready", 64'(req_ready), 64'h4);
    tick();
    check("single_valid", 64'(rsp_valid), 64'h1);
    check("single_data", 64'(rsp_data), 64'h0000_000F);
    check("single_id", 64'(rsp_id), 64'h2);
    clr_reqs();

    // All requesters valid from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'(i), SLL, 6'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(4'b0001 << ord_id[k]));
      tick();
      check("rr_id", 64'(rsp_id), 64'(ord_id[k]));
      check("rr_data", 64'(rsp_data), 64'(ord_data[k]));
    end

    // Backpressure: slot holds id 0 / data 1
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'h0);
      tick();
      check("bp_valid", 64'(rsp_valid), 64'h1);
      check("bp_id", 64'(rsp_id), 64'h0);
      check("bp_data", 64'(rsp_data), 64'h1);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'(4'b0001 << bp_id));
    tick();
    check("bp_release_valid", 64'(rsp_valid), 64'h1);
    check("bp_release_id", 64'(rsp_id), 64'(bp_id));
    check("bp_release_data", 64'(rsp_data), 64'(bp_data));
    clr_reqs();

    // Large and negative shift amounts
    shift_case("sll_rs2_32", 32'hFFFF_FFFF, 32'd32, SLL, 6'd0, 32'h0);
    shift_case("slli_neg1", 32'hFFFF_FFFF, 32'd0, SLLI, 6'b111111, 32'h0);
    shift_case("sll_rs2_31", 32'h1, 32'd31, SLL, 6'd0, 32'h8000_0000);
    shift_case("slri_31", 32'h8000_0000, 32'd0, SLRI, 6'd31, 32'h1);
    shift_case("slli_neg32", 32'h0000_0001, 32'd0, SLLI, 6'b100000, 32'h0);
    shift_case("slr_big", 32'hFFFF_FFFF, 32'hFFFF_FFE0, SLR, 6'd0, 32'h0);
    shift_case("func_unknown", 32'h8000_0000, 32'd4, func_t'(3'd7), 6'd2, 32'h0800_0000);
    clr_reqs();

    // Reset while full
    rsp_ready = 1'b0;
    tick();
    check("full_before_rst", 64'(rsp_valid), 64'h1);
    rst_n = 1'b0;
    tick();
    check("rst_full_valid", 64'(rsp_valid), 64'h0);
    check("rst_full_data", 64'(rsp_data), 64'h0);
    check("rst_full_id", 64'(rsp_id), 64'h0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'h10, 32'd1, SLL, 6'd0);
    #1;
    check("post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    check("post_rst_id", 64'(rsp_id), 64'h0);
    check("post_rst_data", 64'(rsp_data), 64'h20);
    clr_reqs();

    // Idle to burst: sparse requests, pointer moves only on handshakes
    #1;
    check("idle_ready0", 64'(req_ready), 64'h0);
    tick();
    check("idle_pop", 64'(rsp_valid), 64'h0);
    tick();
    check("idle_ready1", 64'(req_ready), 64'h0);
    set_req(3, 32'd3, 32'd1, SLL, 6'd0);
    #1;
    check("sparse3_ready", 64'(req_ready), 64'h8);
    tick();
    check("sparse3_id", 64'(rsp_id), 64'h3);
    check("sparse3_data", 64'(rsp_data), 64'h6);
    clr_reqs();
    #1;
    check("idle_ready2", 64'(req_ready), 64'h0);
    tick();
    check("idle_pop2", 64'(rsp_valid), 64'h0);
    tick();
    set_req(1, 32'hA, 32'd0, SLRI, 6'd1);
    #1;
    check("sparse1_ready", 64'(req_ready), 64'h2);
    tick();
    check("sparse1_id", 64'(rsp_id), 64'h1);
    check("sparse1_data", 64'(rsp_data), 64'h5);
    clr_reqs();
    tick();
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 32'h1, 32'd0, SLL, 6'd0);
    #1;
    check("burst_ready", 64'(req_ready), 64'(final_ready));
    tick();
    clr_reqs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
